cnn_conv_ctrl: RTL and testbench

//  Frame sequencer for the KXxKY convolution datapath (line buffer + cnn_kernel).

---
 rtl/cnn_pkg.sv | 12 +
 rtl/cnn_conv_ctrl_if.sv | 13 +
 rtl/cnn_pos_cnt.sv | 34 +++
 rtl/cnn_conv_ctrl.sv | 94 +++++++++
 tb/tb_cnn_conv_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM states, kernel size defaults and output-size helpers for the conv datapath
package cnn_pkg;
    localparam int KX_DEF = 5;
    localparam int KY_DEF = 5;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    function automatic int out_dim(input int in_d, input int k);
        return in_d - k + 1;
    endfunction
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/cnn_conv_ctrl_if.sv
// cnn_conv_ctrl_if: pixel stream handshake, window strobe/position and kernel result strobe
//   slave  (controller): in  i_in_valid, i_kernel_valid; out o_in_ready, o_win_valid, o_win_col, o_win_row
//   master (source/kernel side): the mirror image
interface cnn_conv_ctrl_if #(parameter int C_BW = 5);
    logic            i_in_valid;
    logic            o_in_ready;
    logic            o_win_valid;
    logic [C_BW-1:0] o_win_col;
    logic [C_BW-1:0] o_win_row;
    logic            i_kernel_valid;
    modport slave  (input i_in_valid, i_kernel_valid, output o_in_ready, o_win_valid, o_win_col, o_win_row);
    modport master (output i_in_valid, i_kernel_valid, input o_in_ready, o_win_valid, o_win_col, o_win_row);
endinterface

// File: rtl/cnn_pos_cnt.sv
// cnn_pos_cnt: raster col/row counter with enable and clear; last_o marks the final pixel of the frame
//   clk, reset_n (async active-low), clr_i (sync clear), en_i (advance), col_o/row_o (position), last_o
module cnn_pos_cnt #(
    parameter int W  = 7,
    parameter int H  = 6,
    parameter int BW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [BW-1:0] col_o,
    output logic [BW-1:0] row_o,
    output logic          last_o
);
    logic [BW-1:0] col_q, row_q;
    logic          col_end;
    assign col_end = col_q == BW'(W - 1);
    assign last_o  = col_end & (row_q == BW'(H - 1));
    assign col_o   = col_q;
    assign row_o   = row_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en_i) begin
            col_q <= col_end ? '0 : col_q + 1'b1;
            row_q <= last_o ? '0 : col_end ? row_q + 1'b1 : row_q;
        end
    end
endmodule

// File: rtl/cnn_conv_ctrl.sv
// cnn_conv_ctrl: frame sequencer for the KXxKY conv datapath (window flags, result count, done/err)
//   clk, reset_n (async active-low), i_start, i_clear, bus (cnn_conv_ctrl_if.slave),
//   o_busy, o_done (1-cycle pulse), o_err (sticky), o_frame_cycles when CNN_CTRL_CYCLE_CNT_EN is defined
module cnn_conv_ctrl
    import cnn_pkg::*;
#(
    parameter int KX   = KX_DEF,
    parameter int KY   = KY_DEF,
    parameter int IN_W = 28,
    parameter int IN_H = 28
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic        i_clear,
    cnn_conv_ctrl_if.slave bus,
    output logic        o_busy,
    output logic        o_done,
`ifdef CNN_CTRL_CYCLE_CNT_EN
    output logic [31:0] o_frame_cycles,
`endif
    output logic        o_err
);
    localparam int OUT_W = out_dim(IN_W, KX);
    localparam int OUT_H = out_dim(IN_H, KY);
    localparam int C_BW  = $clog2(max2(IN_W, IN_H));
    localparam int O_BW  = $clog2(OUT_W * OUT_H + 1);
    localparam logic [O_BW-1:0] TOT = O_BW'(OUT_W * OUT_H);
    state_e          state_q, state_d;
    logic            accept, start_acc, last, res_full;
    logic [C_BW-1:0] col, row, wc_q, wc_d, wr_q, wr_d;
    logic [O_BW-1:0] res_q, res_d;
    logic            err_q, err_d, wv_q, wv_d;
    assign bus.o_in_ready  = state_q == RUN;
    assign accept          = bus.i_in_valid & bus.o_in_ready;
    assign start_acc       = (state_q == IDLE) & i_start & ~i_clear;
    assign res_full        = res_q == TOT;
    assign bus.o_win_valid = wv_q;
    assign bus.o_win_col   = wc_q;
    assign bus.o_win_row   = wr_q;
    assign o_busy          = state_q != IDLE;
    assign o_done          = state_q == DONE;
    assign o_err           = err_q;
    cnn_pos_cnt #(.W(IN_W), .H(IN_H), .BW(C_BW)) u_pos (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (i_clear | start_acc),
        .en_i   (accept),
        .col_o  (col),
        .row_o  (row),
        .last_o (last)
    );
    always_comb begin
        state_d = i_clear            ? IDLE :
                  state_q == IDLE    ? (i_start ? RUN : IDLE) :
                  state_q == RUN     ? (accept & last ? DRAIN : RUN) :
                  state_q == DRAIN   ? (res_full ? DONE : DRAIN) : IDLE;
        wv_d    = accept & (col >= C_BW'(KX - 1)) & (row >= C_BW'(KY - 1)) & ~i_clear;
        wc_d    = wv_d ? col - C_BW'(KX - 1) : wc_q;
        wr_d    = wv_d ? row - C_BW'(KY - 1) : wr_q;
        // a result is unexpected outside RUN/DRAIN or once the frame's quota is already met
        err_d   = start_acc ? 1'b0 :
                  err_q | (bus.i_kernel_valid & ((state_q == IDLE) | (state_q == DONE) | res_full));
        res_d   = (i_clear | start_acc) ? '0 :
                  (bus.i_kernel_valid & ((state_q == RUN) | (state_q == DRAIN)) & ~res_full) ? res_q + 1'b1 : res_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            err_q   <= 1'b0;
            wv_q    <= 1'b0;
            wc_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wv_q    <= wv_d;
            wc_q    <= wc_d;
            wr_q    <= wr_d;
        end
    end
`ifdef CNN_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    // the start cycle itself counts as 1; every non-IDLE cycle through DONE adds one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_q <= '0;
        else if (start_acc) cyc_q <= 32'd1;
        else if ((state_q != IDLE) && (cyc_q != '1)) cyc_q <= cyc_q + 32'd1;
    end
    assign o_frame_cycles = cyc_q;
`endif
endmodule

// File: tb/tb_cnn_conv_ctrl.sv
// tb_cnn_conv_ctrl: randomized self-checking bench with a pixel-index reference model
module tb_cnn_conv_ctrl;
    localparam int KX = 5, KY = 5, IN_W = 7, IN_H = 6;
    localparam int TOT = 6, NPIX = 42, C_BW = 3;
    logic clk = 1'b0, reset_n = 1'b0, i_start, i_clear;
    logic o_busy, o_done, o_err;
`ifdef CNN_CTRL_CYCLE_CNT_EN
    logic [31:0] o_frame_cycles;
`endif
    cnn_conv_ctrl_if #(.C_BW(C_BW)) bus();
    cnn_conv_ctrl #(.KX(KX), .KY(KY), .IN_W(IN_W), .IN_H(IN_H)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .i_start(i_start),
        .i_clear(i_clear),
        .bus    (bus),
        .o_busy (o_busy),
        .o_done (o_done),
`ifdef CNN_CTRL_CYCLE_CNT_EN
        .o_frame_cycles(o_frame_cycles),
`endif
        .o_err  (o_err)
    );
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_st = 0, m_p = 0, m_res = 0, m_wc = 0, m_wr = 0;
    bit m_wv = 0, m_err = 0;
    longint m_cyc = 0;
    bit [1:0] kp = '0;
    int wins = 0, dones = 0, first_c = 0, first_r = 0, last_c = 0, last_r = 0;
    bit got_first = 0;
    int span;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: state 0 idle, 1 run, 2 drain, 3 done; frame position kept as a linear pixel index
    always @(posedge clk or negedge reset_n) begin : model
        bit acc, sa;
        int c, r, nst;
        if (!reset_n) begin
            m_st = 0; m_p = 0; m_res = 0; m_wv = 0; m_wc = 0; m_wr = 0; m_err = 0; m_cyc = 0;
        end else begin
            acc = bus.i_in_valid && m_st == 1;
            sa  = m_st == 0 && i_start && !i_clear;
            c   = m_p % IN_W;
            r   = m_p / IN_W;
            nst = i_clear ? 0 : m_st == 0 ? (i_start ? 1 : 0) :
                  m_st == 1 ? ((acc && m_p == NPIX - 1) ? 2 : 1) :
                  m_st == 2 ? (m_res == TOT ? 3 : 2) : 0;
            m_wv = acc && c >= KX - 1 && r >= KY - 1 && !i_clear;
            if (m_wv) begin
                m_wc = c - (KX - 1);
                m_wr = r - (KY - 1);
            end
            if (sa) m_err = 0;
            else if (bus.i_kernel_valid && (m_st == 0 || m_st == 3 || m_res == TOT)) m_err = 1;
            if (sa) m_cyc = 1;
            else if (m_st != 0 && m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (i_clear || sa) m_res = 0;
            else if (bus.i_kernel_valid && (m_st == 1 || m_st == 2) && m_res < TOT) m_res++;
            if (i_clear || sa) m_p = 0;
            else if (acc) m_p = (m_p + 1) % NPIX;
            m_st = nst;
        end
    end

    always @(negedge clk) begin
        check("in_ready", bus.o_in_ready, m_st == 1);
        check("busy", o_busy, m_st != 0);
        check("done", o_done, m_st == 3);
        check("err", o_err, m_err);
        check("win_valid", bus.o_win_valid, m_wv);
        check("win_col", bus.o_win_col, m_wc);
        check("win_row", bus.o_win_row, m_wr);
`ifdef CNN_CTRL_CYCLE_CNT_EN
        check("frame_cycles", o_frame_cycles, m_cyc);
`endif
        if (bus.o_win_valid) begin
            if (!got_first) begin
                first_c = bus.o_win_col;
                first_r = bus.o_win_row;
                got_first = 1;
            end
            last_c = bus.o_win_col;
            last_r = bus.o_win_row;
            wins++;
        end
        if (o_done) dones++;
    end

    // kernel answers two cycles after each expected window
    task automatic drive(input bit st, input bit cl, input bit iv, input bit ij);
        i_start = st;
        i_clear = cl;
        bus.i_in_valid = iv;
        bus.i_kernel_valid = kp[1] | ij;
        kp = {kp[0], m_wv};
    endtask

    task automatic run_frame(input int mode, input int clr_at, input bit clr_st, input bit inj7,
                             input int start_mid, output int sp);
        bit seen, cl, iv, ij, st, cleared;
        int n;
        wins = 0; dones = 0; got_first = 0; seen = 0; cleared = 0; sp = 1;
        @(negedge clk);
        drive(1, 0, 0, 0);
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (m_st == 0) break;
            if (n == 0) check("err_clear_on_start", o_err, 0);
            if (!seen) sp++;
            seen = seen | o_done;
            cl = clr_at >= 0 && !cleared && m_st == 1 && m_p >= clr_at;
            cleared = cleared | cl;
            iv = mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : 1'($urandom_range(0, 1));
            ij = inj7 && m_st == 2 && m_res == TOT;
            st = n == start_mid || (cl && clr_st);
            drive(st, cl, iv, ij);
        end
        drive(0, 0, 0, 0);
        check("frame_bounded", n < 2000, 1);
    endtask

    task automatic check_clean_frame(input string tag);
        check({tag, "_wins"}, wins, 6);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_first_col"}, first_c, 0);
        check({tag, "_first_row"}, first_r, 0);
        check({tag, "_last_col"}, last_c, 2);
        check({tag, "_last_row"}, last_r, 1);
    endtask

    initial begin
        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_ready", bus.o_in_ready, 0);
        check("rst_win_valid", bus.o_win_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        reset_n = 1'b1;

        run_frame(0, -1, 0, 0, -1, span);
        check_clean_frame("t1");
        check("t1_err", o_err, 0);
`ifdef CNN_CTRL_CYCLE_CNT_EN
        check("t1_cycles_span", o_frame_cycles, span);
        check("t1_cycles_min", span >= 45, 1);
`endif

        run_frame(1, -1, 0, 0, -1, span);
        check_clean_frame("t2");
        repeat (3) begin
            run_frame(2, -1, 0, 0, -1, span);
            check_clean_frame("rand");
        end

        run_frame(0, 20, 0, 0, -1, span);
        check("t3_busy_after_clear", o_busy, 0);
        check("t3_no_done", dones, 0);
        run_frame(0, -1, 0, 0, -1, span);
        check_clean_frame("t3b");

        @(negedge clk);
        drive(0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        check("t4_err_idle_result", o_err, 1);
        run_frame(0, -1, 0, 1, -1, span);
        check("t4_err_extra_result", o_err, 1);
        check("t4_dones", dones, 1);
        run_frame(0, -1, 0, 0, -1, span);
        check("t4_err_cleared", o_err, 0);

        run_frame(0, -1, 0, 0, 10, span);
        check_clean_frame("t5");
        @(negedge clk);
        drive(1, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        check("t5_start_clear_idle", o_busy, 0);
        run_frame(2, 15, 1, 0, -1, span);
        check("t5_run_start_clear_idle", o_busy, 0);

        @(negedge clk);
        drive(1, 0, 0, 0);
        repeat (35) begin
            @(negedge clk);
            drive(0, 0, 1, 0);
        end
        #2 reset_n = 1'b0;
        #1;
        check("async_busy", o_busy, 0);
        check("async_win_valid", bus.o_win_valid, 0);
        check("async_ready", bus.o_in_ready, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        kp = '0;
        reset_n = 1'b1;
        run_frame(2, -1, 0, 0, -1, span);
        check_clean_frame("post_reset");
        check("post_reset_err", o_err, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
